// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Purpose  : Shared types and constants for the two-master memory arbiter.
//             Holds the access sequencer state encoding and master indices.
//  Contents : state_t (ST_IDLE, ST_ADDR, ST_DATA; 2-bit encoding)
//             M_CPU / M_DBG master index constants
//  Options  : none
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no grant outstanding
    ST_ADDR = 2'd1,  // latched request drives the memory
    ST_DATA = 2'd2   // memory output valid, granted master acked
  } state_t;

  // Master indices (single bit: there are only two masters)
  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter2
//  Purpose  : Combinational two-way round-robin arbiter. A lone requester is
//             granted directly; on a tie the master that was not granted last
//             wins.
//  Ports    : req[1:0]     in   eligible request vector (bit n = master n)
//             last_grant   in   index of the most recently granted master
//             grant_valid  out  at least one master is eligible
//             grant_idx    out  index of the winning master
//  Options  : none
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = M_CPU;
    if (req == 2'b11) begin
      grant_idx = ~last_grant;
    end else if (req[1]) begin
      grant_idx = M_DBG;
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one single-port synchronous memory (1-cycle registered
//             read) between the CPU data port (master 0) and the debug/loader
//             port (master 1). Two-phase sequencer: ADDR drives the memory,
//             DATA returns mem_out and pulses the granted master's ack.
//  Ports    : clk, rst_n               clock, synchronous active-low reset
//             m0_req/we/addr/wdata     master 0 request (held until m0_ack)
//             m0_ack, m0_rdata         master 0 completion pulse / read data
//             m1_*                     same set for master 1
//             m1_lock                  (MEM_ARBITER_LOCK_EN only) burst lock
//             mem_we/addr/data         memory write enable, address, wdata
//             mem_out                  memory read data
//             busy                     sequencer not in IDLE
//  Options  : MEM_ARBITER_LOCK_EN - adds m1_lock; a locked master 1 that keeps
//             req high in DATA is re-granted directly for burst loads.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // master 0 (CPU data port)
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  // master 1 (debug / loader port)
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
`ifdef MEM_ARBITER_LOCK_EN
  input  logic                  m1_lock,
`endif
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  // memory side
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out,
  output logic                  busy
);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t                r_state;
  logic                  r_last_grant;  // also the master served by ADDR/DATA
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic [1:0] w_req;
  logic [1:0] w_elig;
  logic       w_arb_valid;
  logic       w_arb_idx;
  logic       w_lock_hold;
  logic       w_sel_valid;
  logic       w_sel_idx;

  assign w_req = {m1_req, m0_req};

  // Arbitration only matters in IDLE and DATA. In DATA the master being acked
  // still has its req high (it may only drop it next cycle), so it is masked
  // out to avoid serving the same request twice.
  always_comb begin
    w_elig = 2'b00;
    case (r_state)
      ST_IDLE: w_elig = w_req;
      ST_DATA: w_elig = w_req & ~{r_last_grant, ~r_last_grant};
      default: w_elig = 2'b00;
    endcase
  end

  rr_arbiter2 u_rr (
    .req         (w_elig),
    .last_grant  (r_last_grant),
    .grant_valid (w_arb_valid),
    .grant_idx   (w_arb_idx)
  );

`ifdef MEM_ARBITER_LOCK_EN
  // A locked loader that keeps requesting is re-granted straight from DATA,
  // bypassing both round-robin and the acked-master mask.
  assign w_lock_hold = (r_state == ST_DATA) && (r_last_grant == M_DBG) &&
                       m1_lock && m1_req;
`else
  assign w_lock_hold = 1'b0;
`endif

  assign w_sel_valid = w_arb_valid | w_lock_hold;
  assign w_sel_idx   = w_lock_hold ? M_DBG : w_arb_idx;

  // --------------------------------------------------------------------------
  // Sequencer and request latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= M_DBG;  // CPU wins the first tie after reset
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DATA: begin
          if (w_sel_valid) begin
            r_state      <= ST_ADDR;
            r_last_grant <= w_sel_idx;
            // Latch the winner so later changes on its bus are ignored
            if (w_sel_idx == M_DBG) begin
              r_we    <= m1_we;
              r_addr  <= m1_addr;
              r_wdata <= m1_wdata;
            end else begin
              r_we    <= m0_we;
              r_addr  <= m0_addr;
              r_wdata <= m0_wdata;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ADDR: r_state <= ST_DATA;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  logic w_in_data;

  // rst_n gates the write strobe and the acks so a reset asserted in ADDR or
  // DATA neither commits a write nor completes a handshake.
  assign mem_we    = (r_state == ST_ADDR) & r_we & rst_n;
  assign mem_addr  = r_addr;
  assign mem_data  = r_wdata;

  assign w_in_data = (r_state == ST_DATA) & rst_n;
  assign m0_ack    = w_in_data & (r_last_grant == M_CPU);
  assign m1_ack    = w_in_data & (r_last_grant == M_DBG);
  assign m0_rdata  = m0_ack ? mem_out : '0;
  assign m1_rdata  = m1_ack ? mem_out : '0;

  assign busy      = (r_state != ST_IDLE);

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter with a behavioural memory
//             and a per-master scoreboard of expected read data.
//  Options  : MEM_ARBITER_LOCK_EN - also exercises the m1 burst lock.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct {
    bit            chk;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_out;
  logic          busy;
`ifdef MEM_ARBITER_LOCK_EN
  logic          m1_lock;
  bit            lock_mode;
`endif

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
`ifdef MEM_ARBITER_LOCK_EN
    .m1_lock  (m1_lock),
`endif
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_out  (mem_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 5) return 16'h1234;
    if (i == 3) return 16'h5555;
    return 16'(i * 16'h0101 + 16'h0A00);
  endfunction

  // Behavioural single-port memory, registered read; preloads on first edge
  logic [DW-1:0] tb_mem [0:(1<<AW)-1];
  logic          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < (1 << AW); i++) tb_mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      tb_mem[mem_addr] <= mem_data;
    end
    mem_out <= tb_mem[mem_addr];
  end

  // Scoreboard state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  op_t  q0[$], q1[$];
  exp_t exp0[$], exp1[$];
  int   served[$];
  int   ack_cyc[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   we_cycles = 0;
  int   busy_low = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_op(input int m, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
    op_t  o;
    exp_t e;
    o.we = we; o.addr = addr; o.data = data;
    e.chk = !we;
    e.data = ref_mem[addr];
    if (we) ref_mem[addr] = data;
    if (m == 0) begin q0.push_back(o); exp0.push_back(e); end
    else        begin q1.push_back(o); exp1.push_back(e); end
  endtask

  task automatic sample_acks();
    exp_t e;
    cyc++;
    if (mem_we) we_cycles++;
    if (m0_ack && m1_ack) check_eq("dual_ack", 1, 0);
    if (m0_ack) begin
      served.push_back(0);
      ack_cyc.push_back(cyc);
      if (exp0.size() == 0) check_eq("m0_unexpected_ack", 1, 0);
      else begin
        e = exp0.pop_front();
        q0.delete(0);
        if (e.chk) check_eq("m0_rdata", 32'(m0_rdata), 32'(e.data));
      end
    end
    if (m1_ack) begin
      served.push_back(1);
      ack_cyc.push_back(cyc);
      if (exp1.size() == 0) check_eq("m1_unexpected_ack", 1, 0);
      else begin
        e = exp1.pop_front();
        q1.delete(0);
        if (e.chk) check_eq("m1_rdata", 32'(m1_rdata), 32'(e.data));
      end
    end
    if (served.size() > 0 && (exp0.size() + exp1.size()) > 0 && !busy) busy_low++;
  endtask

  task automatic tick();
    @(negedge clk);
    sample_acks();
  endtask

  // Present the head of each master's queue; drop req when nothing is left
  task automatic drive();
    if (q0.size() > 0) begin
      m0_req = 1'b1; m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].data;
    end else m0_req = 1'b0;
    if (q1.size() > 0) begin
      m1_req = 1'b1; m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].data;
    end else m1_req = 1'b0;
`ifdef MEM_ARBITER_LOCK_EN
    m1_lock = lock_mode && (q1.size() > 0);
`endif
  endtask

  task automatic run_ops(input int budget);
    int n = 0;
    drive();
    while ((q0.size() + q1.size()) > 0 && n < budget) begin
      tick();
      drive();
      n++;
    end
    if ((q0.size() + q1.size()) > 0) begin
      check_eq("timeout", 0, 1);
      q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
      drive();
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
`ifdef MEM_ARBITER_LOCK_EN
    m1_lock = 1'b0;
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    served.delete(); ack_cyc.delete();
  endtask

  int gaps_bad, repeats, m0_cnt;

  initial begin
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
`ifdef MEM_ARBITER_LOCK_EN
    m1_lock = 0; lock_mode = 0;
`endif
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);

    // Reset state
    repeat (3) tick();
    check_eq("rst_busy",     32'(busy),     0);
    check_eq("rst_acks",     32'({m1_ack, m0_ack}), 0);
    check_eq("rst_mem_we",   32'(mem_we),   0);
    check_eq("rst_mem_addr", 32'(mem_addr), 0);
    check_eq("rst_mem_data", 32'(mem_data), 0);
    check_eq("rst_rdata",    32'({m1_rdata, m0_rdata}), 0);
    rst_n = 1'b1;
    tick();

    // Single read: ADDR in k+1, ack in k+2
    push_op(0, 1'b0, 6'd5, '0);
    drive();
    @(posedge clk); #1;
    check_eq("rd_mem_addr", 32'(mem_addr), 5);
    check_eq("rd_busy",     32'(busy), 1);
    check_eq("rd_early_ack", 32'(m0_ack), 0);
    tick(); drive();
    @(posedge clk); #1;
    check_eq("rd_m0_ack", 32'(m0_ack), 1);
    check_eq("rd_m1_ack", 32'(m1_ack), 0);
    tick(); drive();
    run_ops(10);
    tick();

    // Write by m1, then read back by m0
    we_cycles = 0;
    push_op(1, 1'b1, 6'd10, 16'hBEEF);
    run_ops(20);
    tick();
    check_eq("wr_we_cycles", 32'(we_cycles), 1);
    check_eq("wr_mem10", 32'(tb_mem[10]), 32'h0000BEEF);
    push_op(0, 1'b0, 6'd10, '0);
    run_ops(20);
    tick();

    // Simultaneous requests after reset: m0 then m1, 2 cycles apart
    apply_reset();
    busy_low = 0;
    push_op(0, 1'b0, 6'd1, '0);
    push_op(1, 1'b0, 6'd2, '0);
    run_ops(40);
    check_eq("sim_count", 32'(served.size()), 2);
    if (served.size() == 2) begin
      check_eq("sim_first",  32'(served[0]), 0);
      check_eq("sim_second", 32'(served[1]), 1);
      check_eq("sim_gap",    32'(ack_cyc[1] - ack_cyc[0]), 2);
    end
    check_eq("sim_busy_low", 32'(busy_low), 0);
    tick();

    // Continuous contention: 8 accesses, strict alternation
    served.delete(); ack_cyc.delete();
    for (int k = 0; k < 4; k++) begin
      push_op(0, 1'b0, 6'(40 + k), '0);
      push_op(1, 1'b0, 6'(50 + k), '0);
    end
    run_ops(80);
    check_eq("cont_count", 32'(served.size()), 8);
    gaps_bad = 0; repeats = 0; m0_cnt = 0;
    for (int i = 0; i < served.size(); i++) begin
      if (served[i] == 0) m0_cnt++;
      if (i > 0 && served[i] == served[i-1]) repeats++;
      if (i > 0 && ack_cyc[i] - ack_cyc[i-1] != 2) gaps_bad++;
    end
    check_eq("cont_m0_count", 32'(m0_cnt), 4);
    check_eq("cont_repeats",  32'(repeats), 0);
    check_eq("cont_gaps",     32'(gaps_bad), 0);
    tick();

    // Reset asserted during ADDR of an m1 write
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 6'd3; m1_wdata = 16'hAAAA;
    @(posedge clk); #1;
    check_eq("rm_busy", 32'(busy), 1);
    check_eq("rm_we_addr_phase", 32'(mem_we), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rm_we_gated", 32'(mem_we), 0);
    @(posedge clk); #1;
    check_eq("rm_busy_after", 32'(busy), 0);
    check_eq("rm_ack", 32'({m1_ack, m0_ack}), 0);
    check_eq("rm_mem_addr", 32'(mem_addr), 0);
    check_eq("rm_mem_data", 32'(mem_data), 0);
    check_eq("rm_rdata", 32'(m1_rdata), 0);
    @(negedge clk);
    m1_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check_eq("rm_mem3", 32'(tb_mem[3]), 32'h00005555);

`ifdef MEM_ARBITER_LOCK_EN
    // Locked burst from m1 while m0 waits
    apply_reset();
    lock_mode = 1;
    for (int k = 0; k < 4; k++) push_op(1, 1'b1, 6'(20 + k), 16'(16'hC000 + k));
    drive();
    tick();
    push_op(0, 1'b0, 6'd20, '0);
    run_ops(60);
    lock_mode = 0;
    check_eq("lock_count", 32'(served.size()), 5);
    if (served.size() == 5) begin
      for (int i = 0; i < 4; i++) check_eq("lock_m1_burst", 32'(served[i]), 1);
      check_eq("lock_m0_last", 32'(served[4]), 0);
    end
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_mem_arbiter
`default_nettype wire
